// File: rtl/dcm_reset_ctrl_pkg.sv
// Shared state encoding, reset polarity constants and timer sizing for the
// DCM reset sequencer.
package dcm_reset_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_DCM_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_SOFT      = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // chip_reset polarity: low holds the chip in reset.
    localparam logic RESET_ENABLE = 1'b0;
    localparam logic ENABLE       = 1'b1;

    // Width that can hold every terminal count; at least one bit.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dcm_reset_ctrl_sync_2ff.sv
// One-bit two-flop synchronizer with asynchronous active-low clear; used to
// bring the DCM LOCKED pin into the reference clock domain.
module dcm_reset_ctrl_sync_2ff (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_reset_ctrl.sv
// Reset sequencer: holds the DCM in reset, waits for lock with timeout and
// retries, releases chip reset after a stable-lock window, handles soft reset.
module dcm_reset_ctrl
    import dcm_reset_ctrl_pkg::*;
#(
    parameter int DCM_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRY      = 3,
    parameter int SOFT_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       soft_reset_req,
    output logic       dcm_reset,
    output logic       chip_reset,
    output logic       lock_fail,
    output logic [1:0] retry_cnt,
    output logic [3:0] loss_cnt,
    output state_t     state_dbg
);

    localparam int TW = timer_width(DCM_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, SOFT_CYCLES);

    localparam logic [TW-1:0] DCM_LAST    = TW'(DCM_RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] SOFT_LAST   = TW'(SOFT_CYCLES - 1);
    localparam logic [1:0]    RETRY_LAST  = 2'(MAX_RETRY);

    logic          lock_s;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q;
    logic          timer_clr;
    logic          retry_inc, retry_clr, loss_inc;
    logic          dcm_reset_d, chip_reset_d, lock_fail_d;

    dcm_reset_ctrl_sync_2ff u_lock_sync (
        .clk   (clk),
        .clr_n (reset),
        .d     (locked),
        .q     (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        loss_inc  = 1'b0;

        case (state_q)
            ST_DCM_RST: begin
                if (timer_q == DCM_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (timer_q == LOCK_LAST) begin
                    if (retry_cnt == RETRY_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d   = ST_DCM_RST;
                        retry_inc = 1'b1;
                    end
                end
            end
            ST_STABLE: begin
                // A dropout restarts the window but is not a failed attempt.
                if (!lock_s) state_d = ST_WAIT_LOCK;
                else if (timer_q == STABLE_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d   = ST_DCM_RST;
                    retry_clr = 1'b1;
                    loss_inc  = 1'b1;
                end else if (soft_reset_req) begin
                    state_d = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (!lock_s) begin
                    state_d   = ST_DCM_RST;
                    retry_clr = 1'b1;
                    loss_inc  = 1'b1;
                end else if (timer_q == SOFT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_DCM_RST;
            end
        endcase

        timer_clr = (state_d != state_q);

        // Outputs are decoded from the next state so the flops hold the
        // value that belongs to the state being entered.
        dcm_reset_d  = (state_d == ST_DCM_RST);
        chip_reset_d = (state_d == ST_RUN) ? ENABLE : RESET_ENABLE;
        lock_fail_d  = lock_fail | (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_DCM_RST;
            timer_q    <= '0;
            retry_cnt  <= 2'd0;
            loss_cnt   <= 4'd0;
            dcm_reset  <= 1'b1;
            chip_reset <= RESET_ENABLE;
            lock_fail  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcm_reset  <= dcm_reset_d;
            chip_reset <= chip_reset_d;
            lock_fail  <= lock_fail_d;

            // Every timed state leaves at its terminal count, so no wrap.
            if (timer_clr) begin
                timer_q <= '0;
            end else if (state_q != ST_RUN && state_q != ST_FAIL) begin
                timer_q <= timer_q + 1'b1;
            end

            if (retry_clr) begin
                retry_cnt <= 2'd0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 2'd1;
            end

            if (loss_inc && loss_cnt != 4'hF) begin
                loss_cnt <= loss_cnt + 4'd1;
            end
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// Directed bench for dcm_reset_ctrl: bring-up, soft reset, lock loss and
// saturation, lock glitch, async reset and lock timeout to failure.
module tb_dcm_reset_ctrl;
    import dcm_reset_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       locked;
    logic       soft_reset_req;
    logic       dcm_reset;
    logic       chip_reset;
    logic       lock_fail;
    logic [1:0] retry_cnt;
    logic [3:0] loss_cnt;
    state_t     state_dbg;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int b;
    int exp_loss;

    dcm_reset_ctrl #(
        .DCM_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .STABLE_CYCLES  (16),
        .MAX_RETRY      (2),
        .SOFT_CYCLES    (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .locked         (locked),
        .soft_reset_req (soft_reset_req),
        .dcm_reset      (dcm_reset),
        .chip_reset     (chip_reset),
        .lock_fail      (lock_fail),
        .retry_cnt      (retry_cnt),
        .loss_cnt       (loss_cnt),
        .state_dbg      (state_dbg)
    );

    // Clock and cycle index: cyc==k at the falling edge before rising edge k.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int k);
        if (cyc > k) check("schedule", 32'(cyc), 32'(k));
        while (cyc < k) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic async_reset_pulse();
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dcm"},   32'(dcm_reset),  32'd1);
        check({tag, "_chip"},  32'(chip_reset), 32'd0);
        check({tag, "_fail"},  32'(lock_fail),  32'd0);
        check({tag, "_retry"}, 32'(retry_cnt),  32'd0);
        check({tag, "_loss"},  32'(loss_cnt),   32'd0);
        check({tag, "_state"}, 32'(state_dbg),  32'(ST_DCM_RST));
    endtask

    initial begin
        reset = 1'b0;
        locked = 1'b0;
        soft_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");

        // Normal bring-up: locked at 20 -> lock_s at 22 -> RUN at 39.
        reset = 1'b1;
        goto(3);  check("up_dcm3", 32'(dcm_reset), 32'd1);
        goto(4);  check("up_dcm4", 32'(dcm_reset), 32'd0);
                  check("up_wait", 32'(state_dbg), 32'(ST_WAIT_LOCK));
        goto(20); locked = 1'b1;
        goto(23); check("up_stable", 32'(state_dbg), 32'(ST_STABLE));
        goto(38); check("up_chip38", 32'(chip_reset), 32'd0);
        goto(39); check("up_chip39", 32'(chip_reset), 32'd1);
                  check("up_run", 32'(state_dbg), 32'(ST_RUN));
                  check("up_retry", 32'(retry_cnt), 32'd0);

        // Soft reset sampled at 45: chip low 46..53, high at 54.
        goto(45); soft_reset_req = 1'b1;
        goto(46); soft_reset_req = 1'b0;
                  check("soft_chip46", 32'(chip_reset), 32'd0);
                  check("soft_state", 32'(state_dbg), 32'(ST_SOFT));
        goto(50); check("soft_dcm", 32'(dcm_reset), 32'd0);
        goto(53); check("soft_chip53", 32'(chip_reset), 32'd0);
        goto(54); check("soft_chip54", 32'(chip_reset), 32'd1);

        // Lock loss in RUN: pin low at 60, outputs react at 63.
        goto(60); locked = 1'b0;
        goto(62); check("loss_chip62", 32'(chip_reset), 32'd1);
        goto(63); check("loss_chip63", 32'(chip_reset), 32'd0);
                  check("loss_dcm63", 32'(dcm_reset), 32'd1);
                  check("loss_cnt1", 32'(loss_cnt), 32'd1);
        goto(67); check("loss_dcm67", 32'(dcm_reset), 32'd0);
        goto(70); locked = 1'b1;
        goto(88); check("relock_chip88", 32'(chip_reset), 32'd0);
        goto(89); check("relock_chip89", 32'(chip_reset), 32'd1);

        // Fifteen more losses: count saturates at 15.
        for (int i = 2; i <= 16; i++) begin
            b = cyc + 2;
            goto(b);      locked = 1'b0;
            goto(b + 3);
            exp_loss = (i > 15) ? 15 : i;
            check("sat_loss", 32'(loss_cnt), 32'(exp_loss));
            check("sat_dcm", 32'(dcm_reset), 32'd1);
            goto(b + 7);  locked = 1'b1;
            goto(b + 26); check("sat_chip", 32'(chip_reset), 32'd1);
        end

        // Soft request coinciding with lock loss, then one during STABLE.
        b = cyc + 2;
        goto(b);      locked = 1'b0;
        goto(b + 2);  soft_reset_req = 1'b1;
        goto(b + 3);  soft_reset_req = 1'b0;
                      check("both_state", 32'(state_dbg), 32'(ST_DCM_RST));
                      check("both_dcm", 32'(dcm_reset), 32'd1);
                      check("both_loss", 32'(loss_cnt), 32'd15);
        goto(b + 7);  locked = 1'b1;
        goto(b + 15); soft_reset_req = 1'b1;
        goto(b + 16); soft_reset_req = 1'b0;
                      check("stbl_soft_state", 32'(state_dbg), 32'(ST_STABLE));
        goto(b + 26); check("stbl_soft_chip", 32'(chip_reset), 32'd1);
                      check("stbl_soft_run", 32'(state_dbg), 32'(ST_RUN));

        // Lock glitch during STABLE restarts the window without a retry.
        b = cyc + 2;
        goto(b);      locked = 1'b0;
        goto(b + 7);  locked = 1'b1;
        goto(b + 17); locked = 1'b0;
        goto(b + 18); locked = 1'b1;
        goto(b + 19); check("glitch_stable", 32'(state_dbg), 32'(ST_STABLE));
        goto(b + 20); check("glitch_wait", 32'(state_dbg), 32'(ST_WAIT_LOCK));
        goto(b + 26); check("glitch_chip26", 32'(chip_reset), 32'd0);
        goto(b + 36); check("glitch_chip36", 32'(chip_reset), 32'd0);
        goto(b + 37); check("glitch_chip37", 32'(chip_reset), 32'd1);
                      check("glitch_retry", 32'(retry_cnt), 32'd0);

        // Async reset mid-RUN, then restart with locked already high.
        async_reset_pulse();
        check_reset_values("arst_run");
        release_reset();
        goto(3);  check("rst_dcm3", 32'(dcm_reset), 32'd1);
        goto(4);  check("rst_dcm4", 32'(dcm_reset), 32'd0);
        goto(5);  check("rst_stable", 32'(state_dbg), 32'(ST_STABLE));
        goto(20); check("rst_chip20", 32'(chip_reset), 32'd0);
        goto(21); check("rst_chip21", 32'(chip_reset), 32'd1);

        // Async reset mid-WAIT_LOCK.
        locked = 1'b0;
        reset = 1'b0;
        release_reset();
        goto(10); check("wl_state", 32'(state_dbg), 32'(ST_WAIT_LOCK));
                  check("wl_dcm", 32'(dcm_reset), 32'd0);
        async_reset_pulse();
        check_reset_values("arst_wait");
        release_reset();

        // Lock timeout: pulses at 0, 104, 208; FAIL from 312.
        goto(103); check("to_dcm103", 32'(dcm_reset), 32'd0);
        goto(104); check("to_dcm104", 32'(dcm_reset), 32'd1);
                   check("to_retry1", 32'(retry_cnt), 32'd1);
        goto(107); check("to_dcm107", 32'(dcm_reset), 32'd1);
        goto(108); check("to_dcm108", 32'(dcm_reset), 32'd0);
        goto(207); check("to_dcm207", 32'(dcm_reset), 32'd0);
        goto(208); check("to_dcm208", 32'(dcm_reset), 32'd1);
                   check("to_retry2", 32'(retry_cnt), 32'd2);
        goto(311); check("to_wait311", 32'(state_dbg), 32'(ST_WAIT_LOCK));
                   check("to_fail311", 32'(lock_fail), 32'd0);
        goto(312); check("to_state312", 32'(state_dbg), 32'(ST_FAIL));
                   check("to_fail312", 32'(lock_fail), 32'd1);
                   check("to_retry312", 32'(retry_cnt), 32'd2);
                   check("to_chip312", 32'(chip_reset), 32'd0);
                   check("to_dcm312", 32'(dcm_reset), 32'd0);
        goto(320); locked = 1'b1;
        goto(330); soft_reset_req = 1'b1;
        goto(331); soft_reset_req = 1'b0;
        goto(400); check("fail_hold_state", 32'(state_dbg), 32'(ST_FAIL));
                   check("fail_hold_chip", 32'(chip_reset), 32'd0);
                   check("fail_hold_flag", 32'(lock_fail), 32'd1);
        async_reset_pulse();
        check_reset_values("arst_fail");
        release_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcm_reset_ctrl.md
# dcm_reset_ctrl

Reset sequencer between the board reset switch, the Xilinx DCM and the chip reset net. It holds the DCM in reset for a guaranteed minimum time and waits for lock with a timeout and bounded retries. It releases chip reset only after lock has been stable for a programmable window. It re-runs the sequence on loss of lock and can also issue a short software-requested chip reset without disturbing the DCM.

## Interface
Parameters:
- DCM_RST_CYCLES, 4: cycles dcm_reset is held high per attempt (DCM minimum is 3 CLKIN cycles).
- LOCK_TIMEOUT, 4096: cycles to wait for lock per attempt.
- STABLE_CYCLES, 256: consecutive locked cycles required before chip reset release.
- MAX_RETRY, 3: DCM reset attempts after the first before declaring failure.
- SOFT_CYCLES, 16: chip_reset assertion length for a software request.

Ports:
- clk, in, 1: reference clock (board clk_ref, never the DCM output).
- reset, in, 1: one clock; reset is asynchronous and active-low. Driven by the reset switch.
- locked, in, 1: DCM LOCKED. Asynchronous to clk; synchronised internally.
- soft_reset_req, in, 1: single-cycle pulse requesting a chip-only reset. Synchronous to clk.
- dcm_reset, out, 1: DCM RST, active-high.
- chip_reset, out, 1: chip reset, active-low (0 = RESET_ENABLE).
- lock_fail, out, 1: sticky. Set when retries are exhausted.
- retry_cnt, out, 2: attempts consumed in the current sequence.
- loss_cnt, out, 4: loss-of-lock events while in RUN. Saturates at 15.

## Operation
- Reset values: dcm_reset=1, chip_reset=0, lock_fail=0, retry_cnt=0, loss_cnt=0, state=DCM_RST, timer=0.
- States: DCM_RST, WAIT_LOCK, STABLE, RUN, SOFT, FAIL.
- DCM_RST
  - dcm_reset=1, chip_reset=0.
  - After DCM_RST_CYCLES cycles, go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK
  - dcm_reset=0.
  - lock_s=1 goes to STABLE.
  - If the timer reaches LOCK_TIMEOUT-1 without lock:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - otherwise increment retry_cnt and go to DCM_RST.
- STABLE
  - lock_s held 1 for STABLE_CYCLES consecutive cycles goes to RUN.
  - lock_s=0 returns to WAIT_LOCK with the timer cleared and no retry increment.
- RUN
  - chip_reset=1.
  - lock_s=0: go to DCM_RST, clear retry_cnt, increment loss_cnt (saturating).
  - soft_reset_req=1 with lock_s=1: go to SOFT.
- SOFT
  - chip_reset=0, dcm_reset=0.
  - After SOFT_CYCLES cycles, return to RUN.
  - Loss of lock takes precedence and is handled exactly as in RUN.
- FAIL
  - dcm_reset=0, chip_reset=0, lock_fail=1.
  - Left only by asserting reset.
- soft_reset_req is ignored in every state except RUN.
- Simultaneous lock loss and soft_reset_req in RUN: lock loss wins.
- Timer width: ceil(log2(max of all cycle parameters)).
  - The timer is cleared on every state entry.
  - It never wraps; terminal compare only.
- All outputs are registered; no combinational path from an input to an output.

## Timing
- lock_s is locked delayed by 2 clk cycles (2-FF synchronizer).
- Cycle 0 is the first rising edge with reset high.
  - dcm_reset is high for cycles 0..DCM_RST_CYCLES-1 and low from cycle DCM_RST_CYCLES.
- If WAIT_LOCK samples lock_s=1 at cycle L:
  - STABLE is entered at L+1;
  - chip_reset rises at L+1+STABLE_CYCLES.
- In RUN, with lock_s sampled 0 at cycle P: chip_reset=0 and dcm_reset=1 at P+1.
  - The latency from the locked pin is 3 cycles.
- soft_reset_req sampled at cycle S: chip_reset=0 from S+1 through S+SOFT_CYCLES, and 1 at S+SOFT_CYCLES+1.
- Reset assertion mid-operation, in any state: all outputs return to their reset values immediately (asynchronous).
  - Release is synchronous to the next clk edge.
  - The synchronizer flops are also cleared to 0.

## Structure
- Shared header rst_ctrl.h holds:
  - the 3-bit state encodings (DCM_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, SOFT=4, FAIL=5);
  - the timer width macro.
- The existing RESET_ENABLE/ENABLE macros from the global headers are used for polarity.
- Sub-module sync_2ff: 1-bit two-flop synchronizer with async active-low clear. Instantiated for locked.
- The FSM, timer and counters live in dcm_reset_ctrl.

## Test plan
All scenarios use DCM_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRY=2, SOFT_CYCLES=8.
- Normal bring-up: release reset, raise locked at cycle 20 -> dcm_reset falls at cycle 4; chip_reset rises at cycle 39; retry_cnt=0.
- Lock timeout: locked held 0 -> three dcm_reset pulses of 4 cycles, spaced 104 cycles apart; then FAIL with lock_fail=1, retry_cnt=2, chip_reset=0 forever.
- Lock glitch: locked is 1 for 10 cycles, 0 for 1, then 1 -> STABLE restarts, chip_reset delayed accordingly, retry_cnt unchanged.
- Lock loss in RUN: drop locked -> chip_reset=0 and dcm_reset=1 three cycles later; loss_cnt=1; normal re-lock restores RUN. Repeat 16 times -> loss_cnt stays 15.
- Soft reset: pulse soft_reset_req in RUN -> chip_reset low for exactly 8 cycles; dcm_reset stays 0. A pulse in STABLE is ignored. A pulse coinciding with lock loss takes the lock-loss path.
- Async reset mid-WAIT_LOCK and mid-RUN -> outputs at reset values within the same cycle, without waiting for a clk edge; the sequence restarts from DCM_RST.
